// File: rtl/tx_length_framer_pkg.sv
// tx_length_framer_pkg
//   Shared definitions for the TX length framer: FSM state encoding, the STP
//   token nibble, the link-generation codes that select 128b/130b framing,
//   and the bit offsets of the fields inside the 32-bit STP token.
package tx_length_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_TOKEN = 2'd2,
    ST_DATA  = 2'd3
  } state_e;

  localparam logic [3:0] STP_NIBBLE = 4'hF;

  localparam logic [2:0] GEN3_CODE = 3'b011;
  localparam logic [2:0] GEN4_CODE = 3'b100;
  localparam logic [2:0] GEN5_CODE = 3'b101;

  localparam int TOK_LEN_LSB  = 4;
  localparam int TOK_FCRC_LSB = 15;
  localparam int TOK_PAR_BIT  = 19;
  localparam int TOK_SEQ_LSB  = 20;

  // Gen3 and later links use 128b/130b framing with an STP token.
  function automatic logic is_framed(input logic [2:0] g);
    return (g == GEN3_CODE) || (g == GEN4_CODE) || (g == GEN5_CODE);
  endfunction

endpackage

// File: rtl/tx_stp_token_gen.sv
// tx_stp_token_gen
//   Combinational STP token builder.
//   Ports:
//     length [10:0]     frame length in DWs (TLP DWs plus the token DW)
//     seq    [SEQ_W-1:0] current sequence number
//     token  [31:0]     {seq, parity, FCRC, length, 4'hF}
//   FCRC is the XOR of the three length nibbles (top nibble zero-padded);
//   the parity bit makes bits [19:4] carry an even number of ones.
module tx_stp_token_gen
  import tx_length_framer_pkg::*;
#(
  parameter int SEQ_W = 12
) (
  input  logic [10:0]      length,
  input  logic [SEQ_W-1:0] seq,
  output logic [31:0]      token
);

  logic [3:0]  fcrc;
  logic [11:0] seq_field;

  always_comb begin
    fcrc      = length[3:0] ^ length[7:4] ^ {1'b0, length[10:8]};
    seq_field = 12'(seq);
    token                        = '0;
    token[3:0]                   = STP_NIBBLE;
    token[TOK_LEN_LSB +: 11]     = length;
    token[TOK_FCRC_LSB +: 4]     = fcrc;
    token[TOK_PAR_BIT]           = ^{fcrc, length};
    token[TOK_SEQ_LSB +: 12]     = seq_field;
  end

endmodule

// File: rtl/tx_length_framer.sv
// tx_length_framer
//   Store-and-forward TLP framer. One TLP is buffered, then emitted either
//   behind an STP token (Gen3+ framing) or bare with stp_out on the first DW
//   (legacy). TLPs longer than MAX_DW are truncated and flagged on err_len.
//   Ports:
//     pclk, reset_n        clock, asynchronous active-low reset
//     gen [2:0]            link generation, sampled when the TLP completes
//     tlp_data/valid/last  input DW stream, tlp_ready handshake
//     data_out/valid_out   framed output stream, out_ready handshake
//     stp_out, end_out     first (token/start) and last DW markers
//     length_out [10:0]    length field of the frame being sent
//     err_len              one-cycle pulse when a TLP overflows the buffer
module tx_length_framer
  import tx_length_framer_pkg::*;
#(
  parameter int MAX_DW = 32,
  parameter int SEQ_W  = 12
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [2:0]  gen,
  input  logic [31:0] tlp_data,
  input  logic        tlp_valid,
  input  logic        tlp_last,
  output logic        tlp_ready,
  output logic [31:0] data_out,
  output logic        valid_out,
  input  logic        out_ready,
  output logic        stp_out,
  output logic        end_out,
  output logic [10:0] length_out,
  output logic        err_len
);

  localparam int CW = $clog2(MAX_DW + 1);
  localparam int AW = (MAX_DW > 1) ? $clog2(MAX_DW) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DW);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, cnt_nxt, rd_idx_q;
  logic [SEQ_W-1:0] seq_q;
  logic             framed_q, ovf_q;
  logic [31:0]      buf_mem [MAX_DW];
  logic [31:0]      token;
  logic [AW-1:0]    wr_addr;
  logic             in_acc, out_acc, full, last_rd, framed_now;

  assign in_acc     = tlp_valid & tlp_ready;
  assign out_acc    = valid_out & out_ready;
  assign full       = (count_q == MAX_CNT);
  assign last_rd    = (rd_idx_q == count_q - CW'(1));
  assign framed_now = is_framed(gen);
  assign wr_addr    = (state_q == ST_IDLE) ? '0 : count_q[AW-1:0];

  tx_stp_token_gen #(.SEQ_W(SEQ_W)) u_token (
    .length (length_out),
    .seq    (seq_q),
    .token  (token)
  );

  // Next-state and output decode. tlp_ready is gated by reset_n so nothing
  // is accepted while reset is held.
  always_comb begin
    state_d   = state_q;
    tlp_ready = 1'b0;
    valid_out = 1'b0;
    stp_out   = 1'b0;
    end_out   = 1'b0;
    data_out  = '0;
    cnt_nxt   = count_q;
    unique case (state_q)
      ST_IDLE: begin
        tlp_ready = reset_n;
        cnt_nxt   = CW'(1);
        if (tlp_valid) begin
          if (tlp_last) state_d = framed_now ? ST_TOKEN : ST_DATA;
          else          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        tlp_ready = reset_n;
        cnt_nxt   = full ? count_q : count_q + CW'(1);
        if (tlp_valid && tlp_last) state_d = framed_now ? ST_TOKEN : ST_DATA;
      end
      ST_TOKEN: begin
        valid_out = 1'b1;
        stp_out   = 1'b1;
        data_out  = token;
        if (out_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        valid_out = 1'b1;
        data_out  = buf_mem[rd_idx_q[AW-1:0]];
        stp_out   = !framed_q && (rd_idx_q == '0);
        end_out   = last_rd;
        if (out_ready && last_rd) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer write port; DWs beyond MAX_DW are dropped.
  always_ff @(posedge pclk) begin
    if (in_acc && !(state_q == ST_FILL && full)) buf_mem[wr_addr] <= tlp_data;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_idx_q   <= '0;
      seq_q      <= '0;
      framed_q   <= 1'b0;
      ovf_q      <= 1'b0;
      err_len    <= 1'b0;
      length_out <= '0;
    end else begin
      state_q <= state_d;
      err_len <= 1'b0;
      if (in_acc) begin
        count_q <= cnt_nxt;
        if (state_q == ST_IDLE) begin
          ovf_q <= 1'b0;
        end else if (full && !ovf_q) begin
          ovf_q   <= 1'b1;
          err_len <= 1'b1;
        end
        // Framing mode and length are frozen here for the whole frame.
        if (tlp_last) begin
          framed_q   <= framed_now;
          length_out <= 11'(cnt_nxt) + (framed_now ? 11'd1 : 11'd0);
          rd_idx_q   <= '0;
        end
      end
      if (out_acc && state_q == ST_DATA) begin
        rd_idx_q <= rd_idx_q + CW'(1);
        if (last_rd && framed_q) seq_q <= seq_q + SEQ_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_length_framer.sv
// tb_tx_length_framer
//   Randomized and directed bench for tx_length_framer. A reference model
//   computes the expected output beat list for each TLP from the framing
//   rules (token arithmetic, truncation, legacy markers, sequence count).
module tb_tx_length_framer;

  localparam int MAX_DW = 32;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [10:0] l;
  } beat_t;

  logic        pclk;
  logic        reset_n;
  logic [2:0]  gen;
  logic [31:0] tlp_data;
  logic        tlp_valid;
  logic        tlp_last;
  logic        tlp_ready;
  logic [31:0] data_out;
  logic        valid_out;
  logic        out_ready;
  logic        stp_out;
  logic        end_out;
  logic [10:0] length_out;
  logic        err_len;

  tx_length_framer #(.MAX_DW(MAX_DW), .SEQ_W(12)) dut (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .gen        (gen),
    .tlp_data   (tlp_data),
    .tlp_valid  (tlp_valid),
    .tlp_last   (tlp_last),
    .tlp_ready  (tlp_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .out_ready  (out_ready),
    .stp_out    (stp_out),
    .end_out    (end_out),
    .length_out (length_out),
    .err_len    (err_len)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  logic [11:0] exp_seq = '0;
  logic [31:0] pay[$];
  beat_t       exp_q[$];
  beat_t       got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Token built from plain arithmetic on the field definitions.
  function automatic logic [31:0] token_model(input int len, input logic [11:0] seq);
    int fcrc, par;
    fcrc = (len % 16) ^ ((len / 16) % 16) ^ ((len / 256) % 8);
    par  = ($countones(len) + $countones(fcrc)) % 2;
    return (32'(seq) << 20) | (32'(par) << 19) | (32'(fcrc) << 15) | (32'(len) << 4) | 32'hF;
  endfunction

  task automatic fill_random(input int n);
    pay.delete();
    for (int k = 0; k < n; k++) pay.push_back($urandom);
  endtask

  // Sends the TLP held in pay and collects output beats.
  // stall: 0 = out_ready high, 1 = toggle, 2 = random.
  // abort_beats > 0 stops collecting after that many beats (frame not modelled as complete).
  task automatic run_tlp(input logic [2:0] g, input int stall, input int abort_beats,
                         output int cycles, output int errs);
    int          n, kept, target, i;
    logic        framed, hold_pend;
    logic [31:0] held;
    beat_t       b;
    n         = pay.size();
    framed    = (g == 3'd3) || (g == 3'd4) || (g == 3'd5);
    kept      = (n > MAX_DW) ? MAX_DW : n;
    cycles    = 0;
    errs      = 0;
    i         = 0;
    hold_pend = 1'b0;
    held      = '0;
    exp_q.delete();
    got_q.delete();
    if (framed) begin
      b.d = token_model(kept + 1, exp_seq);
      b.s = 1'b1;
      b.e = 1'b0;
      b.l = 11'(kept + 1);
      exp_q.push_back(b);
    end
    for (int k = 0; k < kept; k++) begin
      b.d = pay[k];
      b.s = !framed && (k == 0);
      b.e = (k == kept - 1);
      b.l = framed ? 11'(kept + 1) : 11'(kept);
      exp_q.push_back(b);
    end
    target = (abort_beats > 0) ? abort_beats : exp_q.size();
    while (got_q.size() < target && cycles < 4000) begin
      #1;
      gen       = (i < n) ? g : 3'($urandom_range(0, 7));
      out_ready = (stall == 0) ? 1'b1 : (stall == 1) ? (cycles % 2 == 0) : 1'($urandom_range(0, 1));
      tlp_valid = (i < n);
      tlp_data  = (i < n) ? pay[i] : $urandom;
      tlp_last  = (i == n - 1);
      #1;
      if (hold_pend) begin
        check("stall_valid", 32'(valid_out), 32'd1);
        check("stall_data", data_out, held);
      end
      hold_pend = valid_out && !out_ready;
      held      = data_out;
      if (tlp_valid && tlp_ready) i++;
      if (valid_out && out_ready) begin
        b.d = data_out;
        b.s = stp_out;
        b.e = end_out;
        b.l = length_out;
        got_q.push_back(b);
      end
      if (err_len) errs++;
      @(posedge pclk);
      cycles++;
    end
    tlp_valid = 1'b0;
    check("beat_count", got_q.size(), target);
    for (int k = 0; k < target && k < got_q.size(); k++) begin
      check($sformatf("beat%0d_data", k), got_q[k].d, exp_q[k].d);
      check($sformatf("beat%0d_stp", k), 32'(got_q[k].s), 32'(exp_q[k].s));
      check($sformatf("beat%0d_end", k), 32'(got_q[k].e), 32'(exp_q[k].e));
      check($sformatf("beat%0d_len", k), 32'(got_q[k].l), 32'(exp_q[k].l));
    end
    if (framed && abort_beats == 0) exp_seq = exp_seq + 12'd1;
  endtask

  initial begin
    int          cyc, errs, bad_gap;
    logic [2:0]  g;
    logic [11:0] s_before;
    reset_n   = 1'b0;
    gen       = 3'd3;
    tlp_data  = '0;
    tlp_valid = 1'b0;
    tlp_last  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_tlp_ready", 32'(tlp_ready), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_stp_out", 32'(stp_out), 32'd0);
    check("rst_end_out", 32'(end_out), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_length_out", 32'(length_out), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge pclk);

    // Gen3, 4-DW TLP with known payload
    pay = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_tlp(3'd3, 0, 0, cyc, errs);
    if (got_q.size() > 0) check("g3_token_const", got_q[0].d, 32'h0002805F);
    if (got_q.size() > 4) check("g3_len_const", 32'(got_q[4].l), 32'd5);
    check("g3_no_err", errs, 0);

    // Legacy 1-DW TLP
    pay = '{32'hAB};
    run_tlp(3'd1, 0, 0, cyc, errs);
    if (got_q.size() > 0) begin
      check("leg_data", got_q[0].d, 32'hAB);
      check("leg_stp_end", {31'd0, got_q[0].s & got_q[0].e}, 32'd1);
      check("leg_len", 32'(got_q[0].l), 32'd1);
    end

    // Following framed frame must still carry seq 1
    fill_random(2);
    run_tlp(3'd5, 0, 0, cyc, errs);
    if (got_q.size() > 0) check("seq_after_legacy", 32'(got_q[0].d[31:20]), 32'd1);

    // Overflow: 40 DWs into a 32-DW buffer
    fill_random(40);
    run_tlp(3'd4, 0, 0, cyc, errs);
    check("ovf_err_pulses", errs, 1);
    check("ovf_beats", got_q.size(), 33);
    if (got_q.size() > 0) check("ovf_len", 32'(got_q[0].l), 32'd33);

    // Output stall toggling every cycle
    fill_random(3);
    run_tlp(3'd3, 1, 0, cyc, errs);
    check("stall_beats", got_q.size(), 4);

    // Random mix of generations, lengths and backpressure
    for (int t = 0; t < 24; t++) begin
      g = 3'($urandom_range(0, 7));
      fill_random($urandom_range(1, 40));
      run_tlp(g, 2, 0, cyc, errs);
      check("rand_err", errs, (pay.size() > MAX_DW) ? 1 : 0);
    end

    // Reset during DATA after token + 2 DWs of a 5-DW frame
    fill_random(5);
    run_tlp(3'd3, 0, 3, cyc, errs);
    #1 reset_n = 1'b0;
    #1;
    check("abort_valid_out", 32'(valid_out), 32'd0);
    check("abort_data_out", data_out, 32'd0);
    check("abort_stp_out", 32'(stp_out), 32'd0);
    check("abort_end_out", 32'(end_out), 32'd0);
    check("abort_length_out", 32'(length_out), 32'd0);
    check("abort_tlp_ready", 32'(tlp_ready), 32'd0);
    exp_seq = '0;
    @(posedge pclk);
    #2 reset_n = 1'b1;
    @(posedge pclk);
    fill_random(2);
    run_tlp(3'd3, 0, 0, cyc, errs);
    if (got_q.size() > 0) check("post_reset_seq", 32'(got_q[0].d[31:20]), 32'd0);

    // 4097 back-to-back 1-DW framed TLPs: seq wraps, 3 cycles per frame
    bad_gap = 0;
    for (int f = 0; f < 4097; f++) begin
      s_before = exp_seq;
      fill_random(1);
      run_tlp(3'd3, 0, 0, cyc, errs);
      if (cyc != 3) bad_gap++;
      if (s_before == 12'hFFF && got_q.size() > 0)
        check("seq_fff", 32'(got_q[0].d[31:20]), 32'hFFF);
      if (s_before == 12'h000 && got_q.size() > 0)
        check("seq_wrap_zero", 32'(got_q[0].d[31:20]), 32'h000);
    end
    check("b2b_frame_cycles", bad_gap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
